airi5c_alu_share_ctrl: RTL and testbench
========================================

# airi5c_alu_share_ctrl

Arbiter and sequencer for the EX-stage ALU and its source-A operand mux. It lets the main pipeline (EX requester) and one auxiliary requester, such as the debug/CSR address-generation path, share a single ALU. It drives the ALU operand-select, operand and opcode lines for the current owner, stalls EX when the auxiliary side owns the ALU, and returns registered results to the auxiliary requester. A saturating starvation counter bounds auxiliary wait time.

## Interface
- XPR_LEN, 32, datapath width
- SRC_A_SEL_WIDTH, 2, width of source-A select code (RS1, PC; other codes give operand 0 downstream)
- OP_WIDTH, 4, ALU opcode width
- STARVE_MAX, 4, auxiliary wait cycles after which auxiliary wins over EX (≥1)

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ex_req_i  in  1  EX wants ALU this cycle
- ex_src_a_sel_i / ex_pc_i / ex_rs1_i / ex_op_i  in  SRC_A_SEL_WIDTH / XPR_LEN / XPR_LEN / OP_WIDTH  EX operand bundle
- ex_gnt_o  out  1  EX owns ALU this cycle
- ex_stall_o  out  1  ex_req_i && !ex_gnt_o
- aux_req_i  in  1  auxiliary request, level, held until granted
- aux_src_a_sel_i / aux_pc_i / aux_rs1_i / aux_op_i  in  as EX  auxiliary operand bundle, stable while aux_req_i is high
- aux_gnt_o  out  1  auxiliary owns ALU this cycle
- aux_rvalid_o  out  1  one-cycle pulse, aux_rdata_o valid
- aux_rdata_o  out  XPR_LEN  registered auxiliary result
- alu_src_a_sel_o / alu_pc_o / alu_rs1_o / alu_op_o  out  as bundle  to ALU source-A mux and ALU
- alu_result_i  in  XPR_LEN  combinational ALU result

## Operation
- Owner is decided combinationally each cycle; at most one grant is high.
  - starve = (cnt_q == STARVE_MAX).
  - ex_gnt_o = ex_req_i && !(starve && aux_req_i).
  - aux_gnt_o = aux_req_i && !ex_gnt_o.
- ALU mux: aux_gnt_o selects the aux bundle; otherwise the EX bundle, including the idle cycle with no grant. The select code passes through unmodified; illegal codes are not trapped here.
- Starvation counter cnt_q, width clog2(STARVE_MAX+1):
  - Cleared when aux_gnt_o or !aux_req_i.
  - Incremented when aux_req_i && !aux_gnt_o.
  - Saturates at STARVE_MAX.
- Auxiliary result: on an aux_gnt_o cycle, alu_result_i is latched into aux_rdata_o and aux_rvalid_o is set for the next cycle only.
  - Back-to-back aux grants produce back-to-back pulses.
  - aux_rdata_o holds its value otherwise.
- The EX result is not registered here. EX consumes alu_result_i directly in its grant cycle.
- After an aux grant, if aux_req_i stays high, it is a new request and the counter restarts at 0.

## Timing
- Reset values: cnt_q=0, aux_rvalid_o=0, aux_rdata_o=0. Grants, ex_stall_o and ALU outputs follow their combinational inputs.
- Latency:
  - EX: 0 cycles; grant in the same cycle when not starved.
  - Aux with EX idle: granted in the same cycle; result 1 cycle later.
  - Aux with EX continuously requesting: granted exactly STARVE_MAX cycles after aux_req_i rises.
- Simultaneous requests with cnt_q<STARVE_MAX: EX wins. With cnt_q==STARVE_MAX: aux wins for one cycle, and ex_stall_o=1 in that cycle.
- Reset mid-operation: an asynchronous assert clears cnt_q and kills any pending aux_rvalid_o immediately. A pending aux request restarts arbitration after reset release.
- aux_req_i dropped before grant is a protocol violation. The counter clears and no result is produced.

## Test plan
- Reset: assert rst_i mid-cycle with cnt_q=3 and aux_rvalid_o=1 → both 0 immediately; aux_rdata_o=0.
- EX only: ex_req_i=1, sel=PC, pc=0x100, op=ADD → ex_gnt_o=1, ex_stall_o=0, alu_pc_o=0x100 in the same cycle, cnt_q stays 0.
- Aux only: aux_req_i=1, rs1=0x20, op=ADD with ALU model result 0x24 → aux_gnt_o=1 in cycle 0; aux_rvalid_o=1 and aux_rdata_o=0x24 in cycle 1; 0 in cycle 2.
- Starvation: ex_req_i and aux_req_i both held high from cycle 0 → ex_gnt_o high in cycles 0–3, cnt_q=1,2,3,4. In cycle 4: aux_gnt_o=1, ex_stall_o=1, ALU driven by the aux bundle. Cycle 5: ex_gnt_o=1, aux_rvalid_o=1. With aux_req_i still high, the next aux grant comes at cycle 9.
- Back-to-back aux with EX idle: aux_req_i high for 3 cycles with results 1,2,3 → aux_rvalid_o high in cycles 1–3 with data 1,2,3.
- Illegal select: aux_src_a_sel_i=3 → alu_src_a_sel_o=3 passed through; the ALU model returns operand 0, latched normally.

Source files
------------

// File: rtl/airi5c_alu_share_ctrl_if.sv
// Operand/handshake bundle between the EX stage, the auxiliary requester, the shared ALU and
// the ALU share controller.
interface airi5c_alu_share_ctrl_if #(
    parameter int XPR_LEN         = 32,
    parameter int SRC_A_SEL_WIDTH = 2,
    parameter int OP_WIDTH        = 4
) ();
    logic                       ex_req_i;
    logic [SRC_A_SEL_WIDTH-1:0] ex_src_a_sel_i;
    logic [XPR_LEN-1:0]         ex_pc_i;
    logic [XPR_LEN-1:0]         ex_rs1_i;
    logic [OP_WIDTH-1:0]        ex_op_i;
    logic                       ex_gnt_o;
    logic                       ex_stall_o;

    logic                       aux_req_i;
    logic [SRC_A_SEL_WIDTH-1:0] aux_src_a_sel_i;
    logic [XPR_LEN-1:0]         aux_pc_i;
    logic [XPR_LEN-1:0]         aux_rs1_i;
    logic [OP_WIDTH-1:0]        aux_op_i;
    logic                       aux_gnt_o;
    logic                       aux_rvalid_o;
    logic [XPR_LEN-1:0]         aux_rdata_o;

    logic [SRC_A_SEL_WIDTH-1:0] alu_src_a_sel_o;
    logic [XPR_LEN-1:0]         alu_pc_o;
    logic [XPR_LEN-1:0]         alu_rs1_o;
    logic [OP_WIDTH-1:0]        alu_op_o;
    logic [XPR_LEN-1:0]         alu_result_i;

    // The controller is the slave; requesters and the ALU sit on the master side.
    modport slave (
        input  ex_req_i, ex_src_a_sel_i, ex_pc_i, ex_rs1_i, ex_op_i,
        output ex_gnt_o, ex_stall_o,
        input  aux_req_i, aux_src_a_sel_i, aux_pc_i, aux_rs1_i, aux_op_i,
        output aux_gnt_o, aux_rvalid_o, aux_rdata_o,
        output alu_src_a_sel_o, alu_pc_o, alu_rs1_o, alu_op_o,
        input  alu_result_i
    );

    modport master (
        output ex_req_i, ex_src_a_sel_i, ex_pc_i, ex_rs1_i, ex_op_i,
        input  ex_gnt_o, ex_stall_o,
        output aux_req_i, aux_src_a_sel_i, aux_pc_i, aux_rs1_i, aux_op_i,
        input  aux_gnt_o, aux_rvalid_o, aux_rdata_o,
        input  alu_src_a_sel_o, alu_pc_o, alu_rs1_o, alu_op_o,
        output alu_result_i
    );
endinterface

// File: rtl/airi5c_alu_share_ctrl.sv
// Shares the EX-stage ALU between the main pipeline and one auxiliary requester. EX has priority
// until the auxiliary side has waited STARVE_MAX cycles; auxiliary results come back registered.
module airi5c_alu_share_ctrl #(
    parameter int XPR_LEN         = 32,
    parameter int SRC_A_SEL_WIDTH = 2,
    parameter int OP_WIDTH        = 4,
    parameter int STARVE_MAX      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    airi5c_alu_share_ctrl_if.slave  bus
);
    localparam int             CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0]      r_cnt;
    logic               r_rvalid;
    logic [XPR_LEN-1:0] r_rdata;

    logic w_starve;
    logic w_ex_gnt;
    logic w_aux_gnt;

    // Arbitration is purely combinational so EX keeps its zero-latency path to the ALU.
    assign w_starve  = (r_cnt == CNT_MAX);
    assign w_ex_gnt  = bus.ex_req_i && !(w_starve && bus.aux_req_i);
    assign w_aux_gnt = bus.aux_req_i && !w_ex_gnt;

    assign bus.ex_gnt_o   = w_ex_gnt;
    assign bus.ex_stall_o = bus.ex_req_i && !w_ex_gnt;
    assign bus.aux_gnt_o  = w_aux_gnt;

    // The EX bundle is the default so idle cycles keep the EX operands on the ALU.
    assign bus.alu_src_a_sel_o = w_aux_gnt ? bus.aux_src_a_sel_i : bus.ex_src_a_sel_i;
    assign bus.alu_pc_o        = w_aux_gnt ? bus.aux_pc_i        : bus.ex_pc_i;
    assign bus.alu_rs1_o       = w_aux_gnt ? bus.aux_rs1_i       : bus.ex_rs1_i;
    assign bus.alu_op_o        = w_aux_gnt ? bus.aux_op_i        : bus.ex_op_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!bus.aux_req_i || w_aux_gnt) begin
            r_cnt <= '0;
        end else if (!w_starve) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_aux_gnt;
            if (w_aux_gnt) begin
                r_rdata <= bus.alu_result_i;
            end
        end
    end

    assign bus.aux_rvalid_o = r_rvalid;
    assign bus.aux_rdata_o  = r_rdata;
endmodule

// File: tb/tb_airi5c_alu_share_ctrl.sv
// Randomized and directed bench for the ALU share controller, checked against a cycle-level
// model of who owns the ALU and what result the auxiliary side should see.
module tb_airi5c_alu_share_ctrl;
    localparam int XL = 32;
    localparam int SW = 2;
    localparam int OW = 4;
    localparam int SM = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    airi5c_alu_share_ctrl_if #(.XPR_LEN(XL), .SRC_A_SEL_WIDTH(SW), .OP_WIDTH(OW)) bus ();

    airi5c_alu_share_ctrl #(.XPR_LEN(XL), .SRC_A_SEL_WIDTH(SW), .OP_WIDTH(OW), .STARVE_MAX(SM)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Toy ALU: source A is RS1 (0), PC (1) or zero; source B is the constant 4.
    function automatic logic [XL-1:0] alu_fn(input logic [SW-1:0] sel, input logic [XL-1:0] pc,
                                             input logic [XL-1:0] rs1, input logic [OW-1:0] op);
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        a = (sel == 2'd0) ? rs1 : (sel == 2'd1) ? pc : '0;
        b = 32'h4;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign bus.alu_result_i = alu_fn(bus.alu_src_a_sel_o, bus.alu_pc_o, bus.alu_rs1_o, bus.alu_op_o);

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: cycles the current aux request has gone unserved, and the pending result.
    int            m_wait   = 0;
    logic          m_rvalid = 1'b0;
    logic [XL-1:0] m_rdata  = '0;
    logic          obs_ag   = 1'b0;

    task automatic tick();
        logic eg, ag;
        logic [SW-1:0] xs;
        logic [XL-1:0] xp, xr;
        logic [OW-1:0] xo;
        #1;
        eg = bus.ex_req_i && !(m_wait >= SM && bus.aux_req_i);
        ag = bus.aux_req_i && !eg;
        xs = ag ? bus.aux_src_a_sel_i : bus.ex_src_a_sel_i;
        xp = ag ? bus.aux_pc_i        : bus.ex_pc_i;
        xr = ag ? bus.aux_rs1_i       : bus.ex_rs1_i;
        xo = ag ? bus.aux_op_i        : bus.ex_op_i;
        chk("ex_gnt",   64'(bus.ex_gnt_o),   64'(eg));
        chk("aux_gnt",  64'(bus.aux_gnt_o),  64'(ag));
        chk("ex_stall", 64'(bus.ex_stall_o), 64'(bus.ex_req_i && !eg));
        chk("alu_sel",  64'(bus.alu_src_a_sel_o), 64'(xs));
        chk("alu_pc",   64'(bus.alu_pc_o),  64'(xp));
        chk("alu_rs1",  64'(bus.alu_rs1_o), 64'(xr));
        chk("alu_op",   64'(bus.alu_op_o),  64'(xo));
        chk("rvalid",   64'(bus.aux_rvalid_o), 64'(m_rvalid));
        chk("rdata",    64'(bus.aux_rdata_o),  64'(m_rdata));
        obs_ag = bus.aux_gnt_o;
        @(posedge clk_i);
        m_rvalid = ag;
        if (ag) m_rdata = alu_fn(bus.aux_src_a_sel_i, bus.aux_pc_i, bus.aux_rs1_i, bus.aux_op_i);
        m_wait = (bus.aux_req_i && !ag) ? m_wait + 1 : 0;
        @(negedge clk_i);
    endtask

    // Reset asserted mid-cycle; registered outputs must clear without waiting for a clock edge.
    task automatic mid_reset();
        rst_i = 1'b1;
        #1;
        m_wait = 0; m_rvalid = 1'b0; m_rdata = '0;
        chk("rst_rvalid", 64'(bus.aux_rvalid_o), 64'(0));
        chk("rst_rdata",  64'(bus.aux_rdata_o),  64'(0));
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic set_ex(input logic req, input logic [SW-1:0] s, input logic [XL-1:0] pc,
                          input logic [XL-1:0] rs1, input logic [OW-1:0] op);
        bus.ex_req_i = req; bus.ex_src_a_sel_i = s; bus.ex_pc_i = pc; bus.ex_rs1_i = rs1; bus.ex_op_i = op;
    endtask

    task automatic set_aux(input logic req, input logic [SW-1:0] s, input logic [XL-1:0] pc,
                           input logic [XL-1:0] rs1, input logic [OW-1:0] op);
        bus.aux_req_i = req; bus.aux_src_a_sel_i = s; bus.aux_pc_i = pc; bus.aux_rs1_i = rs1; bus.aux_op_i = op;
    endtask

    initial begin
        int g1, g2;
        set_ex(1'b0, '0, '0, '0, '0);
        set_aux(1'b0, '0, '0, '0, '0);
        #1;
        chk("reset_rvalid", 64'(bus.aux_rvalid_o), 64'(0));
        chk("reset_rdata",  64'(bus.aux_rdata_o),  64'(0));
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // EX only: PC source, same-cycle grant.
        set_ex(1'b1, 2'd1, 32'h100, 32'h0, 4'd0);
        tick();
        chk("ex_only_pc", 64'(bus.alu_pc_o), 64'h100);
        set_ex(1'b0, '0, '0, '0, '0);

        // Aux only: rs1 0x20 + 4 returned one cycle later.
        set_aux(1'b1, 2'd0, 32'h0, 32'h20, 4'd0);
        tick();
        set_aux(1'b0, '0, '0, '0, '0);
        #1 chk("aux_only_rdata", 64'(bus.aux_rdata_o), 64'h24);
        tick();
        tick();

        // Starvation: grants at cycles 4 and 9 while EX requests every cycle.
        set_ex(1'b1, 2'd0, 32'h40, 32'h1000, 4'd2);
        set_aux(1'b1, 2'd1, 32'h2000, 32'h0, 4'd1);
        g1 = -1; g2 = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_ag) begin
                if (g1 < 0) g1 = i;
                else if (g2 < 0) g2 = i;
            end
        end
        chk("starve_first_gnt",  64'(g1), 64'(4));
        chk("starve_second_gnt", 64'(g2), 64'(9));
        set_ex(1'b0, '0, '0, '0, '0);
        set_aux(1'b0, '0, '0, '0, '0);
        tick();

        // Back-to-back aux grants with results 1, 2, 3.
        for (int i = 0; i < 3; i++) begin
            set_aux(1'b1, 2'd0, 32'h0, 32'hFFFF_FFFD + 32'(i), 4'd0);
            tick();
        end
        set_aux(1'b0, '0, '0, '0, '0);
        tick();
        tick();

        // Illegal select code passes through; operand A is zero in the ALU model.
        set_aux(1'b1, 2'd3, 32'h55, 32'h77, 4'd0);
        tick();
        chk("illegal_sel_rdata", 64'(bus.aux_rdata_o), 64'h4);
        set_aux(1'b0, '0, '0, '0, '0);
        tick();

        // Reset while a result pulse is pending.
        set_aux(1'b1, 2'd0, 32'h0, 32'h123, 4'd3);
        tick();
        set_aux(1'b0, '0, '0, '0, '0);
        mid_reset();
        tick();

        // Reset with the counter at 3: arbitration restarts from zero afterwards.
        set_ex(1'b1, 2'd0, 32'h0, 32'h9, 4'd0);
        set_aux(1'b1, 2'd1, 32'h300, 32'h0, 4'd0);
        for (int i = 0; i < 3; i++) tick();
        mid_reset();
        for (int i = 0; i < 6; i++) tick();

        // Random traffic respecting the aux hold-until-granted protocol.
        for (int n = 0; n < 3000; n++) begin
            int pex;
            pex = (n < 1500) ? 90 : 40;
            set_ex(($urandom_range(99) < pex), SW'($urandom), $urandom, $urandom, OW'($urandom_range(5)));
            if (!(bus.aux_req_i && !obs_ag)) begin
                set_aux(($urandom_range(99) < 50), SW'($urandom), $urandom, $urandom, OW'($urandom_range(5)));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
